picosoc_ram_arb_wb: RTL and testbench

//  Two-master Wishbone arbiter in front of the shared picosoc RAM slave port.

---
 rtl/picosoc_ram_arb_wb_if.sv | 29 ++
 rtl/picosoc_ram_arb_wb.sv | 118 +++++++++++
 tb/tb_picosoc_ram_arb_wb.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/picosoc_ram_arb_wb_if.sv
// Wishbone link bundle for the picosoc RAM arbiter.
// Ports: master/slave modports, plus ram (master view without err).
interface picosoc_ram_arb_wb_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );

  // The RAM has no error line; the arbiter drives it through this view.
  modport ram (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack
  );
endinterface

// File: rtl/picosoc_ram_arb_wb.sv
// Two-master round-robin Wishbone arbiter with per-access ACK watchdog.
// Ports: wb_clk_i, wb_rst_i, m0_if/m1_if (slave), s_if (ram), gnt_o.
module picosoc_ram_arb_wb #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  picosoc_ram_arb_wb_if.slave        m0_if,
  picosoc_ram_arb_wb_if.slave        m1_if,
  picosoc_ram_arb_wb_if.ram          s_if,
  output logic [1:0]                 gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT - 1);
  localparam bit WD_EN = (TIMEOUT != 0);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic g0, g1;
  logic gstb;
  logic wd_err;

  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the master that was not granted last wins.
        if (m0_if.cyc && (!m1_if.cyc || last_q))
          state_d = GNT0;
        else if (m1_if.cyc)
          state_d = GNT1;
      end
      GNT0: if (!m0_if.cyc) state_d = m1_if.cyc ? GNT1 : IDLE;
      GNT1: if (!m1_if.cyc) state_d = m0_if.cyc ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
  end

  always_comb begin
    gstb = 1'b0;
    if (g0) gstb = m0_if.stb;
    if (g1) gstb = m1_if.stb;
  end

  // Error fires on the last tolerated wait cycle; ack absent by construction.
  assign wd_err = WD_EN && gstb && !s_if.ack && (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (!WD_EN || state_q == IDLE || state_d != state_q ||
        s_if.ack || wd_err)
      cnt_d = '0;
    else if (gstb)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    s_if.adr   = '0;
    s_if.dat_w = '0;
    s_if.sel   = '0;
    s_if.we    = 1'b0;
    s_if.cyc   = 1'b0;
    if (g0) begin
      s_if.adr   = m0_if.adr;
      s_if.dat_w = m0_if.dat_w;
      s_if.sel   = m0_if.sel;
      s_if.we    = m0_if.we;
      s_if.cyc   = m0_if.cyc;
    end
    if (g1) begin
      s_if.adr   = m1_if.adr;
      s_if.dat_w = m1_if.dat_w;
      s_if.sel   = m1_if.sel;
      s_if.we    = m1_if.we;
      s_if.cyc   = m1_if.cyc;
    end
  end

  // Strobe is withdrawn in the error cycle so the slave drops the access.
  assign s_if.stb = gstb & ~wd_err;

  assign m0_if.ack   = s_if.ack & g0 & ~wd_err;
  assign m1_if.ack   = s_if.ack & g1 & ~wd_err;
  assign m0_if.err   = wd_err & g0;
  assign m1_if.err   = wd_err & g1;
  assign m0_if.dat_r = g0 ? s_if.dat_r : '0;
  assign m1_if.dat_r = g1 ? s_if.dat_r : '0;

  assign gnt_o = {g1, g0};

endmodule

// File: tb/tb_picosoc_ram_arb_wb.sv
// Scoreboard bench for picosoc_ram_arb_wb with a registered-ACK RAM model.
// Ports: none; drives two masters, models the RAM, checks responses.
module tb_picosoc_ram_arb_wb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  picosoc_ram_arb_wb_if m0();
  picosoc_ram_arb_wb_if m1();
  picosoc_ram_arb_wb_if s();
  logic [1:0] gnt;

  picosoc_ram_arb_wb #(.TIMEOUT(16), .CNT_W(8)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_if(m0.slave), .m1_if(m1.slave), .s_if(s.ram),
    .gnt_o(gnt)
  );

  picosoc_ram_arb_wb_if z0();
  picosoc_ram_arb_wb_if z1();
  picosoc_ram_arb_wb_if zs();
  logic [1:0] zgnt;

  picosoc_ram_arb_wb #(.TIMEOUT(0), .CNT_W(8)) u_dut_nowd (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_if(z0.slave), .m1_if(z1.slave), .s_if(zs.ram),
    .gnt_o(zgnt)
  );

  assign zs.ack   = 1'b0;
  assign zs.dat_r = 32'h0;
  assign zs.err   = 1'b0;
  assign s.err    = 1'b0;

  // RAM model: ack one cycle after the strobe is seen.
  logic [31:0] mem [0:63];
  logic        ack_q;
  logic [31:0] rdat_q;
  logic        ram_dead = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= 1'b0;
      rdat_q <= 32'h0;
    end else begin
      ack_q <= s.cyc & s.stb & ~ack_q & ~ram_dead;
      if (s.cyc && s.stb && !ack_q) begin
        rdat_q <= mem[s.adr[7:2]];
        if (s.we)
          for (int b = 0; b < 4; b++)
            if (s.sel[b]) mem[s.adr[7:2]][b*8 +: 8] <= s.dat_w[b*8 +: 8];
      end
    end
  end
  assign s.ack   = ack_q;
  assign s.dat_r = rdat_q;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          m;
    bit          err;
    bit          chk;
    logic [31:0] dat;
  } exp_t;
  exp_t q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(int m, bit err, bit c, logic [31:0] d);
    exp_t e;
    e.m = m; e.err = err; e.chk = c; e.dat = d;
    q.push_back(e);
  endtask

  task automatic mon_one(int m, logic ack, logic err, logic [31:0] dat);
    exp_t e;
    if (ack || err) begin
      tests++;
      if (ack && err) begin
        fails++;
        $display("FAIL ack_err_m%0d: both asserted", m);
      end else if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_m%0d: unexpected ack=%b err=%b", m, ack, err);
      end else begin
        e = q.pop_front();
        if (e.m != m || e.err != err || (e.chk && e.dat !== dat)) begin
          fails++;
          $display("FAIL sb_m%0d: got err=%b dat=%h expected m%0d err=%b dat=%h",
                   m, err, dat, e.m, e.err, e.dat);
        end
      end
    end
  endtask

  // Monitor: pop and compare on every response; ungranted paths stay quiet.
  always @(negedge clk) begin
    mon_one(0, m0.ack, m0.err, m0.dat_r);
    mon_one(1, m1.ack, m1.err, m1.dat_r);
    tests++;
    if ((!gnt[0] && (m0.ack || m0.err || m0.dat_r != 0)) ||
        (!gnt[1] && (m1.ack || m1.err || m1.dat_r != 0))) begin
      fails++;
      $display("FAIL quiet: gnt=%b m0 ack=%b err=%b dat=%h m1 ack=%b err=%b dat=%h",
               gnt, m0.ack, m0.err, m0.dat_r, m1.ack, m1.err, m1.dat_r);
    end
  end

  task automatic set_m(int m, bit cyc, bit stb, logic [31:0] a,
                       bit we, logic [31:0] d, logic [3:0] sel);
    if (m == 0) begin
      m0.cyc = cyc; m0.stb = stb; m0.adr = a;
      m0.we = we; m0.dat_w = d; m0.sel = sel;
    end else begin
      m1.cyc = cyc; m1.stb = stb; m1.adr = a;
      m1.we = we; m1.dat_w = d; m1.sel = sel;
    end
  endtask

  task automatic drv(int m, logic [31:0] a, bit we, logic [31:0] d,
                     logic [3:0] sel, bit keep);
    int  n = 0;
    bit  done = 0;
    set_m(m, 1, 1, a, we, d, sel);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (m == 0) done = m0.ack | m0.err;
      else        done = m1.ack | m1.err;
    end
    if (!done) chk($sformatf("timeout_m%0d", m), 0, 1);
    @(posedge clk);
    #1;
    set_m(m, keep, 0, a, we, d, sel);
  endtask

  logic [1:0] rec_g[$];
  logic       rec_c1[$];
  logic       rec_a1[$];

  task automatic record(int n);
    rec_g.delete(); rec_c1.delete(); rec_a1.delete();
    repeat (n) begin
      @(negedge clk);
      rec_g.push_back(gnt);
      rec_c1.push_back(m1.cyc);
      rec_a1.push_back(m1.ack);
    end
  endtask

  function automatic logic [1:0] first_nz();
    foreach (rec_g[i]) if (rec_g[i] != 2'b00) return rec_g[i];
    return 2'b00;
  endfunction

  function automatic int idx_of(logic [1:0] v);
    foreach (rec_g[i]) if (rec_g[i] == v) return i;
    return -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    int na;
    int errs[$];
    int zerr;
    int zhold;

    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[4]  = 32'hDEADBEEF;
    mem[5]  = 32'h12345678;
    mem[8]  = 32'hFFFFFFFF;
    mem[9]  = 32'hFFFFFFFF;
    mem[10] = 32'hFFFFFFFF;
    mem[11] = 32'hFFFFFFFF;
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    z0.cyc = 0; z0.stb = 0; z0.adr = 0; z0.we = 0; z0.dat_w = 0; z0.sel = 0;
    z1.cyc = 0; z1.stb = 0; z1.adr = 0; z1.we = 0; z1.dat_w = 0; z1.sel = 0;

    #3;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_scyc", 32'(s.cyc), 0);
    chk("rst_sstb", 32'(s.stb), 0);
    chk("rst_m0ack", 32'(m0.ack), 0);
    #20;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Tie straight out of reset: m0 first, then handover without IDLE.
    @(posedge clk);
    #1;
    push(0, 0, 1, 32'hDEADBEEF);
    push(1, 0, 1, 32'hDEADBEEF);
    fork
      drv(0, 32'h10, 0, 0, 4'hF, 0);
      drv(1, 32'h10, 0, 0, 4'hF, 0);
      record(10);
    join
    chk("tie1_first", 32'(first_nz()), 32'(2'b01));
    i = idx_of(2'b10);
    chk("tie1_handover", (i > 0) ? 32'(rec_g[i-1]) : 32'hFFFF, 32'(2'b01));

    // Second tie goes to m0 again.
    @(posedge clk);
    #1;
    push(0, 0, 1, 32'hDEADBEEF);
    push(1, 0, 1, 32'h12345678);
    fork
      drv(0, 32'h10, 0, 0, 4'hF, 0);
      drv(1, 32'h14, 0, 0, 4'hF, 0);
      record(10);
    join
    chk("tie2_first", 32'(first_nz()), 32'(2'b01));

    // Single m0 read: grant after one cycle, ack the cycle after.
    @(posedge clk);
    #1;
    push(0, 0, 1, 32'hDEADBEEF);
    set_m(0, 1, 1, 32'h10, 0, 0, 4'hF);
    @(negedge clk);
    chk("rd_gnt_c0", 32'(gnt), 0);
    @(negedge clk);
    chk("rd_gnt_c1", 32'(gnt), 32'(2'b01));
    chk("rd_ack_c1", 32'(m0.ack), 0);
    @(negedge clk);
    chk("rd_ack_c2", 32'(m0.ack), 1);
    chk("rd_dat_c2", m0.dat_r, 32'hDEADBEEF);
    chk("rd_m1dat", m1.dat_r, 0);
    @(posedge clk);
    #1;
    set_m(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // m1 locked burst of 4 masked writes while m0 keeps requesting.
    push(1, 0, 0, 0);
    push(1, 0, 0, 0);
    push(1, 0, 0, 0);
    push(1, 0, 0, 0);
    push(0, 0, 1, 32'hFFFF0002);
    fork
      begin
        drv(1, 32'h20, 1, 32'hA5A50001, 4'b0011, 1);
        drv(1, 32'h24, 1, 32'hA5A50002, 4'b0011, 1);
        drv(1, 32'h28, 1, 32'hA5A50003, 4'b0011, 1);
        drv(1, 32'h2C, 1, 32'hA5A50004, 4'b0011, 0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        drv(0, 32'h24, 0, 0, 4'hF, 0);
      end
      record(16);
    join
    na = 0;
    foreach (rec_a1[k]) if (rec_a1[k] && rec_g[k] == 2'b10) na++;
    chk("burst_acks_gnt10", 32'(na), 4);
    i = -1;
    foreach (rec_c1[k]) if (i < 0 && !rec_c1[k]) i = k;
    chk("burst_drop_gnt",
        (i >= 0 && i + 1 < rec_g.size()) ? {30'h0, rec_g[i], 30'h0, rec_g[i+1]} : 32'hFFFF,
        {30'h0, 2'b10, 30'h0, 2'b01});
    chk("burst_mem_2c", mem[11], 32'hFFFF0004);

    // Watchdog: ack withheld, err on the 16th stb cycle, every 16 cycles.
    @(posedge clk);
    #1;
    ram_dead = 1'b1;
    push(0, 1, 0, 0);
    push(0, 1, 0, 0);
    push(0, 1, 0, 0);
    set_m(0, 1, 1, 32'h30, 0, 0, 4'hF);
    i = -1;
    for (int k = 0; k < 80 && errs.size() < 3; k++) begin
      @(negedge clk);
      if (i < 0 && gnt == 2'b01) i = k;
      if (m0.err) begin
        errs.push_back(k - i);
        chk("wd_stb_low", 32'(s.stb), 0);
      end
    end
    @(posedge clk);
    #1;
    set_m(0, 0, 0, 0, 0, 0, 0);
    ram_dead = 1'b0;
    chk("wd_nerr", 32'(errs.size()), 3);
    if (errs.size() == 3) begin
      chk("wd_err1", 32'(errs[0]), 15);
      chk("wd_err2", 32'(errs[1]), 31);
      chk("wd_err3", 32'(errs[2]), 47);
    end
    @(posedge clk);
    #1;

    // Async reset in the middle of an m1 access.
    set_m(1, 1, 1, 32'h10, 0, 0, 4'hF);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_gnt", 32'(gnt), 32'(2'b10));
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_scyc", 32'(s.cyc), 0);
    chk("arst_sstb", 32'(s.stb), 0);
    chk("arst_m1ack", 32'(m1.ack), 0);
    #20;
    set_m(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(0, 0, 1, 32'hDEADBEEF);
    push(1, 0, 1, 32'h12345678);
    fork
      drv(0, 32'h10, 0, 0, 4'hF, 0);
      drv(1, 32'h14, 0, 0, 4'hF, 0);
      record(10);
    join
    chk("post_rst_tie", 32'(first_nz()), 32'(2'b01));

    // Watchdog disabled: ack never comes, no err, grant held.
    @(posedge clk);
    #1;
    z0.cyc = 1; z0.stb = 1; z0.adr = 32'h40; z0.sel = 4'hF;
    @(negedge clk);
    zerr = 0;
    zhold = 0;
    repeat (100) begin
      @(negedge clk);
      if (z0.err || z1.err) zerr++;
      if (zgnt == 2'b01) zhold++;
    end
    chk("nowd_err", 32'(zerr), 0);
    chk("nowd_hold", 32'(zhold), 100);
    z0.cyc = 0; z0.stb = 0;

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
